axi_burst_master: RTL and testbench

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_master.sv | 181 ++++++++++++++++++
 tb/tb_axi_burst_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// AXI4 burst master. A write command streams a seeded counting pattern out
// on W. A read command fetches a burst and counts the beats whose data
// differs from that pattern. Response, ID and RLAST problems set resp_err.
module axi_burst_master #(
   parameter int  ADDR_WIDTH = 32,
   parameter int  DATA_WIDTH = 512,
   parameter int  ID_WIDTH   = 4,
   localparam int LANES      = DATA_WIDTH / 32,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   input  logic [31:0]           cmd_seed,
   output logic                  done,
   output logic                  resp_err,
   output logic [15:0]           mismatch_cnt,
   output logic [ID_WIDTH-1:0]   AWID,
   output logic [ADDR_WIDTH-1:0] AWADDR,
   output logic [7:0]            AWLEN,
   output logic [2:0]            AWSIZE,
   output logic [1:0]            AWBURST,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [DATA_WIDTH-1:0] WDATA,
   output logic [STRB_WIDTH-1:0] WSTRB,
   output logic                  WLAST,
   output logic                  WVALID,
   input  logic                  WREADY,
   input  logic [ID_WIDTH-1:0]   BID,
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY,
   output logic [ID_WIDTH-1:0]   ARID,
   output logic [ADDR_WIDTH-1:0] ARADDR,
   output logic [7:0]            ARLEN,
   output logic [2:0]            ARSIZE,
   output logic [1:0]            ARBURST,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [ID_WIDTH-1:0]   RID,
   input  logic [DATA_WIDTH-1:0] RDATA,
   input  logic [1:0]            RRESP,
   input  logic                  RLAST,
   input  logic                  RVALID,
   output logic                  RREADY
);

   typedef enum logic [2:0] {
      S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [7:0]            beat_q, beat_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [31:0]           seed_q, seed_d;
   logic                  resp_err_q, resp_err_d;
   logic [15:0]           mism_q, mism_d;
   logic                  cmd_ready_q, awvalid_q, wvalid_q, bready_q;
   logic                  arvalid_q, rready_q, done_q;
   logic [DATA_WIDTH-1:0] pattern;
   logic                  last_beat;

   // The write data and the read reference are the same pattern for the current beat.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign pattern[32*k +: 32] = seed_q + 32'(beat_q) * 32'(LANES) + 32'(k);
   end

   assign last_beat = (beat_q == len_q);

   // Next-state and datapath: command capture, beat counting, error and mismatch accounting.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      id_d       = id_q;
      seed_d     = seed_q;
      beat_d     = beat_q;
      resp_err_d = resp_err_q;
      mism_d     = mism_q;
      case (state_q)
         S_IDLE: if (cmd_valid) begin
            addr_d     = cmd_addr;
            len_d      = cmd_len;
            id_d       = cmd_id;
            seed_d     = cmd_seed;
            beat_d     = 8'd0;
            resp_err_d = 1'b0;
            mism_d     = 16'd0;
            state_d    = cmd_write ? S_WADDR : S_RADDR;
         end
         S_WADDR: if (AWREADY) state_d = S_WDATA;
         S_WDATA: if (WREADY) begin
            beat_d = beat_q + 8'd1;
            if (last_beat) state_d = S_WRESP;
         end
         S_WRESP: if (BVALID) begin
            if (BRESP != 2'b00 || BID != id_q) resp_err_d = 1'b1;
            state_d = S_DONE;
         end
         S_RADDR: if (ARREADY) state_d = S_RDATA;
         S_RDATA: if (RVALID) begin
            beat_d = beat_q + 8'd1;
            if (RDATA != pattern && mism_q != 16'hFFFF) mism_d = mism_q + 16'd1;
            if (RRESP != 2'b00 || RID != id_q || RLAST != last_beat) resp_err_d = 1'b1;
            if (RLAST) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered handshake outputs; each VALID/READY is decoded from the next state.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         id_q        <= '0;
         seed_q      <= '0;
         beat_q      <= '0;
         resp_err_q  <= 1'b0;
         mism_q      <= '0;
         cmd_ready_q <= 1'b1;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         id_q        <= id_d;
         seed_q      <= seed_d;
         beat_q      <= beat_d;
         resp_err_q  <= resp_err_d;
         mism_q      <= mism_d;
         cmd_ready_q <= (state_d == S_IDLE);
         awvalid_q   <= (state_d == S_WADDR);
         wvalid_q    <= (state_d == S_WDATA);
         bready_q    <= (state_d == S_WRESP);
         arvalid_q   <= (state_d == S_RADDR);
         rready_q    <= (state_d == S_RDATA);
         done_q      <= (state_d == S_DONE);
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign done         = done_q;
   assign resp_err     = resp_err_q;
   assign mismatch_cnt = mism_q;

   assign AWID    = id_q;
   assign AWADDR  = addr_q;
   assign AWLEN   = len_q;
   assign AWSIZE  = 3'($clog2(STRB_WIDTH));
   assign AWBURST = 2'b01;
   assign AWVALID = awvalid_q;
   assign WDATA   = pattern;
   assign WSTRB   = '1;
   assign WLAST   = last_beat;
   assign WVALID  = wvalid_q;
   assign BREADY  = bready_q;
   assign ARID    = id_q;
   assign ARADDR  = addr_q;
   assign ARLEN   = len_q;
   assign ARSIZE  = 3'($clog2(STRB_WIDTH));
   assign ARBURST = 2'b01;
   assign ARVALID = arvalid_q;
   assign RREADY  = rready_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: a cycle-level AXI slave with optional stalls,
// and a reference model that builds each expected beat from the seed arithmetic.
module tb_axi_burst_master;
   localparam int LANES = 16;

   logic         ACLK = 1'b0, ARESETN = 1'b1;
   logic         cmd_valid = 0, cmd_ready, cmd_write = 0;
   logic [31:0]  cmd_addr = 0, cmd_seed = 0;
   logic [7:0]   cmd_len = 0;
   logic [3:0]   cmd_id = 0;
   logic         done, resp_err;
   logic [15:0]  mismatch_cnt;
   logic [3:0]   AWID, ARID, BID = 0, RID = 0;
   logic [31:0]  AWADDR, ARADDR;
   logic [7:0]   AWLEN, ARLEN;
   logic [2:0]   AWSIZE, ARSIZE;
   logic [1:0]   AWBURST, ARBURST, BRESP = 0, RRESP = 0;
   logic         AWVALID, AWREADY = 0, WLAST, WVALID, WREADY = 0;
   logic         BVALID = 0, BREADY, ARVALID, ARREADY = 0, RLAST = 0, RVALID = 0, RREADY;
   logic [511:0] WDATA, RDATA = 0;
   logic [63:0]  WSTRB;

   int n_checks = 0, n_fail = 0;

   // observations collected by the slave drivers
   logic [511:0] wq_data[$];
   bit           wq_last[$];
   int done_count, done_cyc, b_hs_cyc, w_first, w_last, bready_first;
   int stable_err, bready_drop, aw_cnt, ar_cnt, w_before_aw, rbeats, sent_bad;
   bit awv_n1, arv_n1;
   logic [31:0] cap_addr;
   logic [7:0]  cap_len;
   logic [3:0]  cap_id;

   axi_burst_master dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_seed(cmd_seed),
      .done(done), .resp_err(resp_err), .mismatch_cnt(mismatch_cnt),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   // beat b, lane k holds seed + b*LANES + k
   function automatic logic [511:0] exp_beat(input logic [31:0] s, input int b);
      logic [511:0] v;
      for (int k = 0; k < LANES; k++) v[32*k +: 32] = s + 32'(b * LANES + k);
      return v;
   endfunction

   function automatic int count_bad_beats(input logic [31:0] s);
      int n = 0;
      for (int b = 0; b < wq_data.size(); b++) if (wq_data[b] !== exp_beat(s, b)) n++;
      return n;
   endfunction

   function automatic int count_bad_last(input logic [7:0] len);
      int n = 0;
      for (int b = 0; b < wq_last.size(); b++) if (wq_last[b] != (b == int'(len))) n++;
      return n;
   endfunction

   task automatic clear_obs();
      wq_data.delete(); wq_last.delete();
      done_count = 0; done_cyc = -1; b_hs_cyc = -1; w_first = -1; w_last = -1;
      bready_first = -1; stable_err = 0; bready_drop = 0; aw_cnt = 0; ar_cnt = 0;
      w_before_aw = 0; rbeats = 0; sent_bad = 0;
   endtask

   // Issue a write command (entered and left at a falling edge) and act as the slave.
   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                           input logic [31:0] seed, input int stall_beat, input int stall_cycles,
                           input bit rnd, input int bdelay, input logic [1:0] bresp,
                           input logic [3:0] bid);
      int cyc = 0, stalled = 0, bwait = 0;
      bit pv = 0, b_done = 0;
      logic [511:0] pd;
      logic pl;
      clear_obs();
      cmd_valid = 1; cmd_write = 1; cmd_addr = addr; cmd_len = len; cmd_id = id; cmd_seed = seed;
      @(negedge ACLK);
      cmd_valid = 0;
      awv_n1 = AWVALID;
      while (cyc < 600 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
         AWREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (AWVALID && AWREADY) begin
            aw_cnt++; cap_addr = AWADDR; cap_len = AWLEN; cap_id = AWID;
         end
         if (WVALID) begin
            if (aw_cnt == 0) w_before_aw++;
            if (pv && (WDATA !== pd || WLAST !== pl)) stable_err++;
            if (rnd) WREADY = 1'($urandom_range(0, 1));
            else if (wq_data.size() == stall_beat && stalled < stall_cycles) begin
               WREADY = 0; stalled++;
            end else WREADY = 1;
            if (WREADY) begin
               wq_data.push_back(WDATA); wq_last.push_back(WLAST);
               if (w_first < 0) w_first = cyc;
               w_last = cyc; pv = 0;
            end else begin
               pv = 1; pd = WDATA; pl = WLAST;
            end
         end else begin
            WREADY = 0; pv = 0;
         end
         if (BREADY && !b_done) begin
            if (bready_first < 0) bready_first = cyc;
            BVALID = (bwait >= bdelay); BID = bid; BRESP = bresp;
            if (BVALID) begin b_done = 1; b_hs_cyc = cyc; end
            bwait++;
         end else begin
            if (!b_done && bwait > 0) bready_drop++;
            BVALID = 0;
         end
         if (done) begin done_count++; if (done_cyc < 0) done_cyc = cyc; end
         @(negedge ACLK); cyc++;
      end
      AWREADY = 0; WREADY = 0; BVALID = 0;
   endtask

   // Issue a read command and act as the slave; RLAST is placed on beat last_beat.
   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input logic [31:0] seed, input logic [31:0] mem_seed, input int last_beat,
                          input logic [1:0] rresp, input logic [3:0] rid, input bit rnd,
                          input bit corrupt);
      int cyc = 0;
      bit ar_done = 0;
      logic [255:0] bad;
      logic [511:0] rd;
      clear_obs();
      for (int i = 0; i < 256; i++) bad[i] = corrupt && ($urandom_range(0, 2) == 0);
      cmd_valid = 1; cmd_write = 0; cmd_addr = addr; cmd_len = len; cmd_id = id; cmd_seed = seed;
      @(negedge ACLK);
      cmd_valid = 0;
      arv_n1 = ARVALID;
      while (cyc < 600 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
         if (ar_done && rbeats <= last_beat && done_cyc < 0) begin
            RVALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rd = exp_beat(mem_seed, rbeats);
            if (bad[rbeats % 256]) rd[(rbeats * 37) % 512] = ~rd[(rbeats * 37) % 512];
            RDATA = rd; RLAST = (rbeats == last_beat); RID = rid; RRESP = rresp;
            if (RVALID && RREADY) begin
               if (RDATA !== exp_beat(seed, rbeats)) sent_bad++;
               rbeats++;
            end
         end else RVALID = 0;
         ARREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (ARVALID && ARREADY) begin
            ar_cnt++; ar_done = 1; cap_addr = ARADDR; cap_len = ARLEN; cap_id = ARID;
         end
         if (done) begin done_count++; if (done_cyc < 0) done_cyc = cyc; end
         @(negedge ACLK); cyc++;
      end
      ARREADY = 0; RVALID = 0; RLAST = 0;
   endtask

   task automatic test_reset();
      #1 ARESETN = 0;
      cmd_valid = 1; cmd_write = 1;
      #2;
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      n_checks++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin n_fail++;
         $display("FAIL reset_handshakes: got %b want 00000", {AWVALID, WVALID, BREADY, ARVALID, RREADY}); end
      n_checks++; if ({done, resp_err, mismatch_cnt} !== 18'd0) begin n_fail++;
         $display("FAIL reset_status: got done=%b err=%b mism=%0d want 0", done, resp_err, mismatch_cnt); end
      n_checks++; if (AWSIZE !== 3'd6 || ARSIZE !== 3'd6 || AWBURST !== 2'b01 || ARBURST !== 2'b01) begin n_fail++;
         $display("FAIL size_burst: got %0d/%0d %b/%b want 6/6 01/01", AWSIZE, ARSIZE, AWBURST, ARBURST); end
      n_checks++; if (WSTRB !== '1) begin n_fail++; $display("FAIL wstrb: got %h want all ones", WSTRB); end
      repeat (2) @(negedge ACLK);
      ARESETN = 1;
      #1;
      n_checks++; if (cmd_ready !== 1'b1 || AWVALID !== 1'b0) begin n_fail++;
         $display("FAIL release_no_early_change: got ready=%b awvalid=%b want 1/0", cmd_ready, AWVALID); end
      #1 cmd_valid = 0;
      @(negedge ACLK);
      n_checks++; if (cmd_ready !== 1'b1 || AWVALID !== 1'b0) begin n_fail++;
         $display("FAIL idle_after_release: got ready=%b awvalid=%b want 1/0", cmd_ready, AWVALID); end
   endtask

   task automatic test_write_basic();
      logic [511:0] b2;
      logic [3:0] wl;
      do_write(32'h100, 8'd3, 4'h5, 32'h1000, -1, 0, 0, 0, 2'b00, 4'h5);
      n_checks++; if (wq_data.size() != 4) begin n_fail++; $display("FAIL wr_beats: got %0d want 4", wq_data.size()); end
      b2 = (wq_data.size() > 2) ? wq_data[2] : '0;
      n_checks++; if (b2[31:0] !== 32'h1020) begin n_fail++; $display("FAIL wr_beat2_lane0: got %h want 00001020", b2[31:0]); end
      n_checks++; if (count_bad_beats(32'h1000) != 0) begin n_fail++;
         $display("FAIL wr_data: got %0d bad beats want 0", count_bad_beats(32'h1000)); end
      wl = '0;
      for (int b = 0; b < 4 && b < wq_last.size(); b++) wl[b] = wq_last[b];
      n_checks++; if (wl !== 4'b1000) begin n_fail++; $display("FAIL wr_wlast: got %b want 1000", wl); end
      n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL wr_done_pulse: got %0d want 1", done_count); end
      n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL wr_resp_err: got %b want 0", resp_err); end
      n_checks++; if (cap_addr !== 32'h100 || cap_len !== 8'd3 || cap_id !== 4'h5) begin n_fail++;
         $display("FAIL wr_aw_fields: got %h/%0d/%h want 100/3/5", cap_addr, cap_len, cap_id); end
      n_checks++; if (!awv_n1) begin n_fail++; $display("FAIL wr_aw_latency: got %b want 1", awv_n1); end
      n_checks++; if (w_last - w_first != 3) begin n_fail++; $display("FAIL wr_consecutive: got span %0d want 3", w_last - w_first); end
      n_checks++; if (bready_first != w_last + 1) begin n_fail++;
         $display("FAIL wr_bready_timing: got cycle %0d want %0d", bready_first, w_last + 1); end
      n_checks++; if (done_cyc != b_hs_cyc + 1) begin n_fail++;
         $display("FAIL wr_done_timing: got cycle %0d want %0d", done_cyc, b_hs_cyc + 1); end
      n_checks++; if (w_before_aw != 0) begin n_fail++; $display("FAIL wr_w_before_aw: got %0d want 0", w_before_aw); end
   endtask

   task automatic test_read();
      do_read(32'h100, 8'd3, 4'h6, 32'h1000, 32'h1000, 3, 2'b00, 4'h6, 0, 0);
      n_checks++; if (mismatch_cnt !== 16'd0 || resp_err !== 1'b0) begin n_fail++;
         $display("FAIL rd_match: got mism=%0d err=%b want 0/0", mismatch_cnt, resp_err); end
      n_checks++; if (done_count != 1 || rbeats != 4) begin n_fail++;
         $display("FAIL rd_done_beats: got done=%0d beats=%0d want 1/4", done_count, rbeats); end
      n_checks++; if (cap_addr !== 32'h100 || cap_len !== 8'd3 || cap_id !== 4'h6 || !arv_n1) begin n_fail++;
         $display("FAIL rd_ar_fields: got %h/%0d/%h lat=%b want 100/3/6 lat=1", cap_addr, cap_len, cap_id, arv_n1); end
      do_read(32'h100, 8'd3, 4'h6, 32'h2000, 32'h1000, 3, 2'b00, 4'h6, 0, 0);
      n_checks++; if (mismatch_cnt !== 16'd4 || resp_err !== 1'b0) begin n_fail++;
         $display("FAIL rd_mismatch: got mism=%0d err=%b want 4/0", mismatch_cnt, resp_err); end
   endtask

   task automatic test_stall();
      do_write(32'h400, 8'd3, 4'h2, 32'hDEAD0000, 1, 3, 0, 5, 2'b00, 4'h2);
      n_checks++; if (stable_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", stable_err); end
      n_checks++; if (wq_data.size() != 4 || count_bad_beats(32'hDEAD0000) != 0 || count_bad_last(8'd3) != 0) begin n_fail++;
         $display("FAIL stall_beats: got %0d beats, %0d bad want 4/0", wq_data.size(), count_bad_beats(32'hDEAD0000)); end
      n_checks++; if (bready_drop != 0 || b_hs_cyc - bready_first != 5) begin n_fail++;
         $display("FAIL stall_bready_hold: got drops=%0d wait=%0d want 0/5", bready_drop, b_hs_cyc - bready_first); end
      n_checks++; if (done_count != 1 || done_cyc != b_hs_cyc + 1) begin n_fail++;
         $display("FAIL stall_done: got %0d pulses at %0d want 1 at %0d", done_count, done_cyc, b_hs_cyc + 1); end
   endtask

   task automatic test_errors();
      do_write(32'h800, 8'd1, 4'h1, 32'h5, -1, 0, 0, 0, 2'b10, 4'h1);
      n_checks++; if (resp_err !== 1'b1 || done_count != 1) begin n_fail++;
         $display("FAIL err_bresp: got err=%b done=%0d want 1/1", resp_err, done_count); end
      do_read(32'h800, 8'd3, 4'h1, 32'h5, 32'h5, 1, 2'b00, 4'h1, 0, 0);
      n_checks++; if (resp_err !== 1'b1 || done_count != 1 || rbeats != 2) begin n_fail++;
         $display("FAIL err_early_rlast: got err=%b done=%0d beats=%0d want 1/1/2", resp_err, done_count, rbeats); end
   endtask

   task automatic test_reset_midburst();
      int cyc = 0, nb = 0, dn = 0;
      logic [511:0] seen;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h200; cmd_len = 8'd5; cmd_id = 4'h3; cmd_seed = 32'hABCD0000;
      @(negedge ACLK);
      cmd_valid = 0; AWREADY = 1; WREADY = 1;
      while (cyc < 50 && !(WVALID && nb == 2)) begin
         if (WVALID) nb++;
         if (done) dn++;
         @(negedge ACLK); cyc++;
      end
      seen = WDATA;
      WREADY = 0; AWREADY = 0;
      n_checks++; if (!(WVALID && nb == 2) || seen !== exp_beat(32'hABCD0000, 2)) begin n_fail++;
         $display("FAIL mid_reach_beat2: got wvalid=%b nb=%0d lane0=%h", WVALID, nb, seen[31:0]); end
      #2 ARESETN = 0;
      #1;
      n_checks++; if (WVALID !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || BREADY !== 1'b0) begin n_fail++;
         $display("FAIL mid_async_reset: got wvalid=%b ready=%b done=%b bready=%b want 0/1/0/0", WVALID, cmd_ready, done, BREADY); end
      @(negedge ACLK);
      if (done) dn++;
      ARESETN = 1;
      n_checks++; if (dn != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses want 0", dn); end
      do_write(32'h300, 8'd0, 4'h9, 32'h77, -1, 0, 0, 0, 2'b00, 4'h9);
      n_checks++; if (wq_data.size() != 1 || count_bad_beats(32'h77) != 0 || count_bad_last(8'd0) != 0) begin n_fail++;
         $display("FAIL len0_write: got %0d beats, %0d bad", wq_data.size(), count_bad_beats(32'h77)); end
      n_checks++; if (done_count != 1 || resp_err !== 1'b0) begin n_fail++;
         $display("FAIL len0_write_done: got done=%0d err=%b want 1/0", done_count, resp_err); end
      do_read(32'h300, 8'd0, 4'h9, 32'h77, 32'h77, 0, 2'b00, 4'h9, 0, 0);
      n_checks++; if (done_count != 1 || resp_err !== 1'b0 || mismatch_cnt !== 16'd0 || rbeats != 1) begin n_fail++;
         $display("FAIL len0_read: got done=%0d err=%b mism=%0d beats=%0d want 1/0/0/1", done_count, resp_err, mismatch_cnt, rbeats); end
   endtask

   task automatic test_random();
      logic [31:0] addr, seed;
      logic [7:0]  len;
      logic [3:0]  id, xid;
      logic [1:0]  rsp;
      int last, bdel;
      bit exp_err;
      for (int it = 0; it < 20; it++) begin
         addr = $urandom & 32'hFFFF_FFC0; len = 8'($urandom_range(0, 12));
         id = 4'($urandom); seed = $urandom;
         rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         xid = ($urandom_range(0, 5) == 0) ? (id ^ 4'h1) : id;
         if ($urandom_range(0, 1) == 1) begin
            bdel = $urandom_range(0, 4);
            do_write(addr, len, id, seed, -1, 0, 1, bdel, rsp, xid);
            exp_err = (rsp != 2'b00) || (xid != id);
            n_checks++; if (wq_data.size() != int'(len) + 1 || count_bad_beats(seed) != 0 || count_bad_last(len) != 0
                            || stable_err != 0) begin n_fail++;
               $display("FAIL rnd_write_%0d: got %0d beats bad=%0d unstable=%0d want %0d", it, wq_data.size(),
                        count_bad_beats(seed), stable_err, len + 1); end
            n_checks++; if (resp_err !== exp_err || done_count != 1 || cap_addr !== addr || cap_len !== len) begin n_fail++;
               $display("FAIL rnd_write_status_%0d: got err=%b done=%0d want err=%b done=1", it, resp_err, done_count, exp_err); end
         end else begin
            last = ($urandom_range(0, 5) == 0) ? ((len > 0) ? $urandom_range(0, int'(len) - 1) : 1) : int'(len);
            do_read(addr, len, id, seed, seed, last, rsp, xid, 1, 1);
            exp_err = (rsp != 2'b00) || (xid != id) || (last != int'(len));
            n_checks++; if (mismatch_cnt !== 16'(sent_bad) || rbeats != last + 1) begin n_fail++;
               $display("FAIL rnd_read_%0d: got mism=%0d beats=%0d want %0d/%0d", it, mismatch_cnt, rbeats, sent_bad, last + 1); end
            n_checks++; if (resp_err !== exp_err || done_count != 1 || cap_addr !== addr) begin n_fail++;
               $display("FAIL rnd_read_status_%0d: got err=%b done=%0d want err=%b done=1", it, resp_err, done_count, exp_err); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read();
      test_stall();
      test_errors();
      test_reset_midburst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
